// File: rtl/fetch_queue.sv
// Instruction fetch front end: single-outstanding ibus requests feeding a {pc, instr} FIFO.
// Optional performance counters are enabled by defining FETCHQ_PERF_EN.
module fetch_queue #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned DEPTH   = 4,
  parameter logic [ADDR_W-1:0] PC_INIT = ADDR_W'('h8000_0000),
  localparam int unsigned CW = $clog2(DEPTH) + 1,
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               ireq_valid,
  output logic [ADDR_W-1:0]  ireq_addr,
  input  logic               iresp_data_ok,
  input  logic [INSTR_W-1:0] iresp_data,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               out_ready,
  output logic [CW-1:0]      count
`ifdef FETCHQ_PERF_EN
  ,
  output logic [63:0]        perf_req,
  output logic [63:0]        perf_discard,
  output logic [63:0]        perf_starve
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [PW-1:0]       rd_q, wr_q;
  logic [CW-1:0]       count_q, count_d;
  logic [ADDR_W-1:0]   pc_mem  [DEPTH];
  logic [INSTR_W-1:0]  ins_mem [DEPTH];
  logic                push, pop, issue, issued;
  logic [ADDR_W-1:0]   rpc;
  logic                unused_rpc_lsbs;

  assign rpc             = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_rpc_lsbs = ^redirect_pc[1:0];

  assign ireq_valid = (state_q != IDLE);
  assign ireq_addr  = addr_q;
  assign out_valid  = (count_q != '0);
  assign out_pc     = out_valid ? pc_mem[rd_q]  : '0;
  assign out_instr  = out_valid ? ins_mem[rd_q] : '0;
  assign count      = count_q;

  always_comb begin
    push     = (state_q == WAIT) && iresp_data_ok && !redirect_valid;
    pop      = out_valid && out_ready && !redirect_valid;
    count_d  = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
    issue    = fetch_en && (count_d < CW'(DEPTH));
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    issued     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_d = rpc;
        end else if (issue) begin
          state_d = WAIT;
          addr_d  = fetch_pc_q;
          issued  = 1'b1;
        end
      end
      WAIT: begin
        if (iresp_data_ok) begin
          // A redirect landing with the response drops it and restarts at rpc.
          fetch_pc_d = redirect_valid ? rpc : addr_q + ADDR_W'(4);
          if (issue) begin
            addr_d = fetch_pc_d;
            issued = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (redirect_valid) begin
          state_d    = DISCARD;
          fetch_pc_d = rpc;
        end
      end
      DISCARD: begin
        if (redirect_valid) fetch_pc_d = rpc;
        if (iresp_data_ok) begin
          if (issue) begin
            state_d = WAIT;
            addr_d  = fetch_pc_d;
            issued  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= PC_INIT;
      addr_q     <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      if (redirect_valid) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + PW'(1);
        if (pop)  rd_q <= rd_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]  <= addr_q;
      ins_mem[wr_q] <= iresp_data;
    end
  end

`ifdef FETCHQ_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_req     <= '0;
      perf_discard <= '0;
      perf_starve  <= '0;
    end else begin
      if (issued) perf_req <= perf_req + 64'd1;
      if (iresp_data_ok && ((state_q == DISCARD) || (state_q == WAIT && redirect_valid)))
        perf_discard <= perf_discard + 64'd1;
      if (out_ready && !out_valid) perf_starve <= perf_starve + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: queue/bus-level reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_fetch_queue;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 1'b0;
  logic [2:0]  count;
`ifdef FETCHQ_PERF_EN
  logic [63:0] perf_req, perf_discard, perf_starve;
`endif

  fetch_queue #(.ADDR_W(64), .INSTR_W(32), .DEPTH(D), .PC_INIT(64'h8000_0000)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .count(count)
`ifdef FETCHQ_PERF_EN
    , .perf_req(perf_req), .perf_discard(perf_discard), .perf_starve(perf_starve)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: an outstanding-request flag, a keep/drop flag and a plain queue.
  typedef struct packed {logic [63:0] pc; logic [31:0] ins;} ent_t;
  ent_t        mq[$];
  bit          m_out, m_keep, m_can;
  logic [63:0] m_addr, m_pc, m_rpc;
  longint unsigned m_req, m_disc, m_starve;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_out = 0; m_keep = 0; m_addr = '0; m_pc = 64'h8000_0000;
      m_req = 0; m_disc = 0; m_starve = 0;
    end else begin
      m_rpc = {redirect_pc[63:2], 2'b00};
      if (out_ready && mq.size() == 0) m_starve++;
      if (redirect_valid) mq.delete();
      else begin
        if (out_ready && mq.size() > 0) void'(mq.pop_front());
        if (m_out && m_keep && iresp_data_ok) mq.push_back({m_addr, iresp_data});
      end
      m_can = fetch_en && (mq.size() < D);
      if (!m_out) begin
        if (redirect_valid) m_pc = m_rpc;
        else if (m_can) begin m_out = 1; m_keep = 1; m_addr = m_pc; m_req++; end
      end else if (iresp_data_ok) begin
        if (redirect_valid) m_pc = m_rpc;
        else if (m_keep) m_pc = m_addr + 64'd4;
        if (!m_keep || redirect_valid) m_disc++;
        if (m_can) begin m_keep = 1; m_addr = m_pc; m_req++; end
        else m_out = 0;
      end else if (redirect_valid) begin
        m_pc = m_rpc;
        m_keep = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("ireq_valid", 64'(ireq_valid), 64'(m_out));
      if (m_out) check("ireq_addr", ireq_addr, m_addr);
      check("count", 64'(count), 64'(mq.size()));
      check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      if (mq.size() > 0) begin
        check("out_pc", out_pc, mq[0].pc);
        check("out_instr", 64'(out_instr), 64'(mq[0].ins));
      end else begin
        check("out_pc_idle", out_pc, 64'd0);
        check("out_instr_idle", 64'(out_instr), 64'd0);
      end
`ifdef FETCHQ_PERF_EN
      check("perf_req", perf_req, m_req);
      check("perf_discard", perf_discard, m_disc);
      check("perf_starve", perf_starve, m_starve);
`endif
    end
  end

  // Bus responder: data_ok after `lat` waiting cycles, data = 0x13 + response index.
  bit auto_resp = 1;
  int lat = 0, wcnt = 0, nresp = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
    if (auto_resp) begin
      if (ireq_valid) begin
        if (wcnt == lat) begin
          iresp_data_ok = 1'b1;
          iresp_data = 32'h13 + 32'(nresp);
          nresp++;
          wcnt = 0;
        end else begin
          iresp_data_ok = 1'b0;
          wcnt++;
        end
      end else begin
        iresp_data_ok = 1'b0;
        wcnt = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    iresp_data_ok = 1'b0;
    redirect_valid = 1'b0;
    wcnt = 0; nresp = 0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Sequential fetch, back-to-back responses, consumer always ready
    fetch_en = 1; out_ready = 1; lat = 0;
    do_reset();
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    cyc();
    check("s1_first_valid", 64'(ireq_valid), 64'd1);
    check("s1_first_addr", ireq_addr, 64'h8000_0000);
    cyc();
    check("s1_head_pc", out_pc, 64'h8000_0000);
    check("s1_head_instr", 64'(out_instr), 64'h13);
    check("s1_req2_addr", ireq_addr, 64'h8000_0004);
    cyc();
    check("s1_head2_pc", out_pc, 64'h8000_0004);
    check("s1_head2_instr", 64'(out_instr), 64'h14);
    repeat (6) cyc();

    // Full queue stalls issue, then resumes without loss
    out_ready = 0;
    do_reset();
    repeat (8) cyc();
    check("s2_full_count", 64'(count), 64'd4);
    check("s2_full_noreq", 64'(ireq_valid), 64'd0);
    check("s2_full_head", out_pc, 64'h8000_0000);
    out_ready = 1;
    cyc();
    check("s2_resume_valid", 64'(ireq_valid), 64'd1);
    check("s2_resume_addr", ireq_addr, 64'h8000_0010);
    check("s2_resume_count", 64'(count), 64'd3);
    check("s2_resume_head", out_pc, 64'h8000_0004);
    repeat (8) cyc();
    fetch_en = 0;
    repeat (8) cyc();
    check("s2_drained", 64'(count), 64'd0);
    check("s2_drained_noreq", 64'(ireq_valid), 64'd0);

    // Redirect while waiting, response delayed 3 cycles
    fetch_en = 1; out_ready = 1; lat = 3;
    do_reset();
    cyc();
    redirect_valid = 1; redirect_pc = 64'h8000_0100;
    cyc();
    redirect_valid = 0;
    check("s3_discard_valid", 64'(ireq_valid), 64'd1);
    check("s3_discard_addr", ireq_addr, 64'h8000_0000);
    cyc(); cyc(); cyc();
    check("s3_new_addr", ireq_addr, 64'h8000_0100);
    check("s3_count", 64'(count), 64'd0);
`ifdef FETCHQ_PERF_EN
    check("s3_perf_discard", perf_discard, 64'd1);
    check("s3_perf_req", perf_req, 64'd2);
`endif
    repeat (10) cyc();

    // Redirect coincident with data_ok and a pop
    lat = 0;
    do_reset();
    repeat (4) cyc();
    check("s4_pre_count", 64'(count), 64'd1);
    redirect_valid = 1; redirect_pc = 64'h8000_0203;
    cyc();
    redirect_valid = 0;
    check("s4_count", 64'(count), 64'd0);
    check("s4_out_valid", 64'(out_valid), 64'd0);
    check("s4_req_valid", 64'(ireq_valid), 64'd1);
    check("s4_req_addr", ireq_addr, 64'h8000_0200);
    repeat (5) cyc();

    // Asynchronous reset during WAIT, stale data_ok afterwards
    out_ready = 0;
    do_reset();
    repeat (3) cyc();
    check("s5_pre_count", 64'(count), 64'd2);
    #1 reset = 1'b1;
    #1;
    check("s5_rst_req", 64'(ireq_valid), 64'd0);
    check("s5_rst_outv", 64'(out_valid), 64'd0);
    check("s5_rst_count", 64'(count), 64'd0);
    check("s5_rst_pc", out_pc, 64'd0);
    check("s5_rst_instr", 64'(out_instr), 64'd0);
    auto_resp = 0;
    iresp_data_ok = 1'b1; iresp_data = 32'hdead_beef;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    wcnt = 0; nresp = 0;
    cyc();
    iresp_data_ok = 1'b0;
    check("s5_first_addr", ireq_addr, 64'h8000_0000);
    check("s5_first_valid", 64'(ireq_valid), 64'd1);
    check("s5_count", 64'(count), 64'd0);
    auto_resp = 1; out_ready = 1;
    repeat (6) cyc();
    check("s5_head_instr_or_empty", 64'(count <= 3'd1), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Next-generation instruction fetch front end, sitting between the PC/redirect logic and decode.
- Fetches sequentially over the ibus valid/data_ok handshake and buffers {pc, instr} pairs in a parametrised FIFO, so fetch is decoupled from decode stalls.
- Handles redirects (branch mispredict, CSR/trap) by flushing the queue and discarding any in-flight response, which the single-register fetch stage cannot do.

Parameters:
- ADDR_W, 64, width of PC and bus address.
- INSTR_W, 32, instruction width.
- DEPTH, 4, queue entries; power of two, ≥2.
- PC_INIT, 64'h8000_0000, fetch PC after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- fetch_en  in  1  permits issuing new requests; never cancels one already issued.
- redirect_valid  in  1  flush the queue and restart at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch PC; bits [1:0] are ignored (forced 0).
- ireq_valid  out  1  bus request valid.
- ireq_addr  out  ADDR_W  bus request address.
- iresp_data_ok  in  1  single-cycle response strobe.
- iresp_data  in  INSTR_W  response data, valid when iresp_data_ok=1.
- out_valid  out  1  queue head valid.
- out_pc  out  ADDR_W  PC of the head entry.
- out_instr  out  INSTR_W  instruction of the head entry.
- out_ready  in  1  consumer pops the head when out_valid & out_ready.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- All state resets asynchronously on reset=1:
  - fetch_pc=PC_INIT, state=IDLE, count=0.
  - ireq_valid=0, out_valid=0; out_pc/out_instr read 0.
- Reset mid-transaction abandons the transaction; a late data_ok while state=IDLE is ignored.
- States:
  - IDLE: no request.
  - WAIT: request outstanding; its data is kept.
  - DISCARD: request outstanding; its data is dropped.
- ireq_valid=1 in WAIT and DISCARD and is registered. ireq_addr holds the issued address stable until data_ok. A request is never withdrawn.
- At most one outstanding request.
- Issue condition: fetch_en & (count_next < DEPTH). count_next counts this cycle's push and pop, so a push never hits a full queue.
- IDLE:
  - Redirect → fetch_pc=redirect_pc; stay IDLE.
  - Issue condition true → WAIT, ireq_addr=fetch_pc, from the next cycle.
  - First request appears the first clk edge after reset deassertion: ireq_valid=1 at cycle 1 with PC_INIT.
- WAIT, data_ok=1 and no redirect:
  - Push {ireq_addr, iresp_data}; fetch_pc=ireq_addr+4.
  - Issue condition true → stay WAIT with the new addr (back-to-back, 1 request per cycle throughput); otherwise → IDLE.
- WAIT, redirect=1 with data_ok=0 → DISCARD; queue flushed; fetch_pc=redirect_pc.
- WAIT, redirect=1 with data_ok=1 → response dropped, queue flushed, fetch_pc=redirect_pc; next state follows the issue condition evaluated with count_next=0.
- DISCARD:
  - On data_ok: drop the data, then issue at fetch_pc (WAIT) if fetch_en, else IDLE.
  - A further redirect in DISCARD only updates fetch_pc.
- Queue:
  - Circular buffer; rd/wr pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves count unchanged; pushing when empty is not visible until the next cycle (no bypass).
  - Pop when out_valid=0 is ignored.
- Priority: redirect > push/pop. In a redirect cycle both pop and push are suppressed and count becomes 0 the next cycle.
- Arithmetic: fetch_pc+4 wraps modulo 2^ADDR_W.
- count output is the registered occupancy.

Optional Feature:
- FETCHQ_PERF_EN defined adds three 64-bit outputs, all reset to 0 and wrapping at 2^64:
  - perf_req: number of issued requests.
  - perf_discard: responses dropped due to redirect.
  - perf_starve: cycles with out_ready=1 & out_valid=0.
- Without the macro these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset release, fetch_en=1, data_ok the cycle after each request, data=0x13+n, out_ready=1 → requests at 0x8000_0000, _0004, _0008…; out_pc/out_instr match pairwise, each entry appears 1 cycle after its data_ok.
- out_ready=0, DEPTH=4 → exactly 4 responses accepted, then ireq_valid=0, count=4. Raise out_ready → issue resumes at 0x8000_0010 and no entry is lost.
- Redirect to 0x8000_0100 while WAIT with data_ok delayed 3 cycles → state DISCARD, addr stays stable, returned data dropped; next request at 0x8000_0100, count=0.
- Redirect coincident with data_ok and out_ready → nothing pushed or popped, count=0; next ireq_addr=redirect_pc.
- Reset asserted during WAIT → outputs zero immediately (asynchronous); after release the first request is at PC_INIT, and a stale data_ok is ignored.
- With FETCHQ_PERF_EN: the third scenario yields perf_discard=1 and perf_req equal to the number of issued addresses.
